chan_select: RTL and testbench

Channel selector and frame reader for the polyphase channelizer output stream. It consumes channelizer frames: NUM_CHAN complex samples per frame, bin 0 first, tlast on the final bin. It forwards only the bins enabled in a host-programmed mask and emits one output packet per input frame, with tlast on the last forwarded bin. It sits between the channelizer and the AXI wrapper's s_axis_data port inside the RFNoC block. It also checks frame alignment and counts framing errors.

---
 rtl/chan_select.sv | 116 +++++++++++
 tb/tb_chan_select.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_select.sv
// chan_select: forwards the host-selected bins of each channelizer frame as one
// output packet, and counts beats where tlast disagrees with the bin count.
module chan_select #(
   parameter int          NUM_CHAN     = 128,
   parameter int          WIDTH        = 32,
   parameter logic [7:0]  SR_MASK_BASE = 8'd160
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                set_stb,
   input  logic [7:0]          set_addr,
   input  logic [31:0]         set_data,
   input  logic [WIDTH-1:0]    i_tdata,
   input  logic                i_tlast,
   input  logic                i_tvalid,
   output logic                i_tready,
   output logic [WIDTH-1:0]    o_tdata,
   output logic                o_tlast,
   output logic                o_tvalid,
   input  logic                o_tready,
   output logic [15:0]         sync_err_cnt,
   output logic [NUM_CHAN-1:0] active_mask
);
   localparam int            BW       = $clog2(NUM_CHAN);
   localparam int            NWORDS   = (NUM_CHAN + 31) / 32;
   localparam logic [BW-1:0] LAST_BIN = BW'(NUM_CHAN - 1);

   logic [NUM_CHAN-1:0] r_shadow;
   logic [NUM_CHAN-1:0] r_active;
   logic [BW-1:0]       r_bin;
   logic [BW-1:0]       r_last_sel;
   logic [15:0]         r_err_cnt;
   logic                r_o_tvalid;
   logic                r_o_tlast;
   logic [WIDTH-1:0]    r_o_tdata;

   logic [NWORDS-1:0]   w_word_hit;
   logic [BW-1:0]       w_shadow_top;
   logic [NUM_CHAN-1:0] w_mask;
   logic [BW-1:0]       w_last_sel;
   logic                w_accept;
   logic                w_bin_last;
   logic                w_frame_end;
   logic                w_err;
   logic                w_sel;

   always_comb begin
      for (int k = 0; k < NWORDS; k++) begin
         w_word_hit[k] = set_stb && (set_addr == 8'(SR_MASK_BASE + k));
      end
   end

   always_comb begin
      w_shadow_top = '0;
      for (int b = 0; b < NUM_CHAN; b++) begin
         if (r_shadow[b]) w_shadow_top = BW'(b);
      end
   end

   // On bin 0 the shadow is committed this very cycle, so it also governs that beat.
   assign w_mask      = (r_bin == '0) ? r_shadow : r_active;
   assign w_last_sel  = (r_bin == '0) ? w_shadow_top : r_last_sel;
   assign w_sel       = w_mask[r_bin];
   assign i_tready    = ~r_o_tvalid | o_tready;
   assign w_accept    = i_tvalid & i_tready;
   assign w_bin_last  = (r_bin == LAST_BIN);
   assign w_frame_end = i_tlast | w_bin_last;
   assign w_err       = i_tlast ^ w_bin_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow <= '0;
      end else begin
         for (int b = 0; b < NUM_CHAN; b++) begin
            if (w_word_hit[b / 32]) r_shadow[b] <= set_data[b % 32];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bin      <= '0;
         r_active   <= '0;
         r_last_sel <= '0;
         r_err_cnt  <= '0;
      end else if (w_accept) begin
         r_bin <= w_frame_end ? '0 : r_bin + BW'(1);
         if (r_bin == '0) begin
            r_active   <= r_shadow;
            r_last_sel <= w_shadow_top;
         end
         if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_o_tvalid <= 1'b0;
         r_o_tdata  <= '0;
         r_o_tlast  <= 1'b0;
      end else if (w_accept && w_sel) begin
         r_o_tvalid <= 1'b1;
         r_o_tdata  <= i_tdata;
         r_o_tlast  <= (r_bin == w_last_sel) | i_tlast;
      end else if (o_tready) begin
         r_o_tvalid <= 1'b0;
      end
   end

   assign o_tvalid     = r_o_tvalid;
   assign o_tdata      = r_o_tdata;
   assign o_tlast      = r_o_tlast;
   assign sync_err_cnt = r_err_cnt;
   assign active_mask  = r_active;

endmodule

// File: tb/tb_chan_select.sv
// Bench for chan_select: frame-level reference model with an output queue,
// plus literal expectations for the directed scenarios.
module tb_chan_select;
   localparam int NC = 128;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          set_stb  = 1'b0;
   logic [7:0]    set_addr = '0;
   logic [31:0]   set_data = '0;
   logic [31:0]   i_tdata  = '0;
   logic          i_tlast  = 1'b0;
   logic          i_tvalid = 1'b0;
   logic          i_tready;
   logic [31:0]   o_tdata;
   logic          o_tlast;
   logic          o_tvalid;
   logic          o_tready = 1'b1;
   logic [15:0]   sync_err_cnt;
   logic [NC-1:0] active_mask;

   int n_checks = 0;
   int n_errors = 0;
   int rdy_mode = 0;

   logic [NC-1:0] m_shadow;
   logic [NC-1:0] m_active;
   int            m_bin;
   int            m_last;
   int            m_err;
   logic [32:0]   exp_q[$];
   logic [32:0]   got_q[$];
   logic          p_stall = 1'b0;
   logic [31:0]   p_data;
   logic          p_last;

   chan_select #(.NUM_CHAN(NC), .WIDTH(32), .SR_MASK_BASE(8'd160)) dut (
      .clk(clk), .reset(reset),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .sync_err_cnt(sync_err_cnt), .active_mask(active_mask)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         1:       o_tready = 1'($urandom_range(0, 1));
         2:       o_tready = 1'b0;
         default: o_tready = 1'b1;
      endcase
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int top_bin(input logic [NC-1:0] m);
      top_bin = 0;
      for (int b = 0; b < NC; b++) if (m[b]) top_bin = b;
   endfunction

   // Inputs settle at posedge+1; sampling here sees exactly what the next edge will act on.
   always @(negedge clk) begin
      if (reset) begin
         m_shadow = '0;
         m_active = '0;
         m_bin    = 0;
         m_last   = 0;
         m_err    = 0;
         exp_q.delete();
         p_stall  = 1'b0;
      end else begin
         check("i_tready", i_tready, !o_tvalid || o_tready);
         check("active_mask", active_mask, m_active);
         check("sync_err_cnt", sync_err_cnt, m_err);
         if (p_stall) begin
            check("stall_valid", o_tvalid, 1'b1);
            check("stall_data", {o_tlast, o_tdata}, {p_last, p_data});
         end
         if (o_tvalid && o_tready) begin
            got_q.push_back({o_tlast, o_tdata});
            check("output_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("output_beat", {o_tlast, o_tdata}, exp_q.pop_front());
         end
         if (i_tvalid && i_tready) begin
            if (m_bin == 0) begin
               m_active = m_shadow;
               m_last   = top_bin(m_shadow);
            end
            if (m_active[m_bin]) exp_q.push_back({(m_bin == m_last) || i_tlast, i_tdata});
            if (i_tlast != (m_bin == NC - 1)) m_err = (m_err < 65535) ? m_err + 1 : 65535;
            m_bin = (i_tlast || (m_bin == NC - 1)) ? 0 : m_bin + 1;
         end
         if (set_stb) begin
            for (int k = 0; k < 4; k++) begin
               if (set_addr == 8'(160 + k)) m_shadow[32*k +: 32] = set_data;
            end
         end
         p_stall = o_tvalid && !o_tready;
         p_data  = o_tdata;
         p_last  = o_tlast;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int k, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = 8'(160 + k);
      set_data = d;
      tick();
      set_stb  = 1'b0;
   endtask

   task automatic set_mask(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
      write_word(0, w0);
      write_word(1, w1);
      write_word(2, w2);
      write_word(3, w3);
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      logic acc;
      int   guard;
      acc      = 1'b0;
      guard    = 0;
      i_tvalid = 1'b1;
      i_tdata  = d;
      i_tlast  = l;
      while (!acc && guard < 1000) begin
         @(negedge clk);
         acc = i_tready;
         tick();
         guard++;
      end
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
      if (!acc) check("send_timeout", acc, 1'b1);
   endtask

   task automatic send_frame(input int base, input int n, input int last_at);
      for (int i = 0; i < n; i++) send(32'(base + i), i == last_at);
   endtask

   task automatic drain();
      rdy_mode = 0;
      repeat (12) tick();
      check("drained", exp_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int nlast;
      repeat (3) tick();
      check("rst_o_tvalid", o_tvalid, 1'b0);
      check("rst_o_tdata", o_tdata, 32'd0);
      check("rst_o_tlast", o_tlast, 1'b0);
      check("rst_err", sync_err_cnt, 16'd0);
      check("rst_mask", active_mask, '0);
      reset = 1'b0;
      tick();
      check("rst_i_tready", i_tready, 1'b1);

      // bins 0 and 2 only
      set_mask(32'h5, 0, 0, 0);
      got_q.delete();
      send_frame(0, NC, NC - 1);
      send_frame(0, NC, NC - 1);
      drain();
      check("t1_count", got_q.size(), 4);
      check("t1_b0", got_q[0], {1'b0, 32'd0});
      check("t1_b1", got_q[1], {1'b1, 32'd2});
      check("t1_b3", got_q[3], {1'b1, 32'd2});
      check("t1_err", sync_err_cnt, 16'd0);

      // all bins, random backpressure
      set_mask('1, '1, '1, '1);
      got_q.delete();
      rdy_mode = 1;
      for (int f = 0; f < 2; f++) begin
         for (int b = 0; b < NC; b++) send({16'(f), 16'(b)}, b == NC - 1);
      end
      drain();
      nlast = 0;
      foreach (got_q[i]) if (got_q[i][32]) nlast++;
      check("t2_count", got_q.size(), 256);
      check("t2_nlast", nlast, 2);
      check("t2_last127", got_q[127], {1'b1, 16'd0, 16'd127});
      check("t2_b200", got_q[200], {1'b0, 16'd1, 16'd72});

      // mask rewritten mid-frame: bin 3 -> bin 127
      set_mask(32'h8, 0, 0, 0);
      got_q.delete();
      for (int b = 0; b < NC; b++) begin
         if (b == 60) begin set_stb = 1'b1; set_addr = 8'd160; set_data = 32'h0; end
         if (b == 61) begin set_stb = 1'b1; set_addr = 8'd163; set_data = 32'h8000_0000; end
         send(32'(b), b == NC - 1);
         set_stb = 1'b0;
      end
      send_frame(0, NC, NC - 1);
      drain();
      check("t3_count", got_q.size(), 2);
      check("t3_f1", got_q[0], {1'b1, 32'd3});
      check("t3_f2", got_q[1], {1'b1, 32'd127});

      // truncated frame: tlast at bin 9
      set_mask('1, '1, '1, '1);
      got_q.delete();
      send_frame(0, 10, 9);
      send_frame(1000, NC, NC - 1);
      drain();
      check("t4_count", got_q.size(), 138);
      check("t4_b9", got_q[9], {1'b1, 32'd9});
      check("t4_next", got_q[10], {1'b0, 32'd1000});
      check("t4_err", sync_err_cnt, 16'd1);

      // long frame: 130 beats, tlast only on the last
      got_q.delete();
      send_frame(2000, 130, 129);
      drain();
      check("t5_count", got_q.size(), 130);
      check("t5_b127", got_q[127], {1'b1, 32'd2127});
      check("t5_b128", got_q[128], {1'b0, 32'd2128});
      check("t5_b129", got_q[129], {1'b1, 32'd2129});
      check("t5_err", sync_err_cnt, 16'd3);

      // async reset with output pending
      rdy_mode = 2;
      repeat (2) tick();
      send(32'd5000, 1'b0);
      check("t6_pending", o_tvalid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_o_tvalid", o_tvalid, 1'b0);
      check("t6_o_tdata", o_tdata, 32'd0);
      check("t6_o_tlast", o_tlast, 1'b0);
      check("t6_mask", active_mask, '0);
      check("t6_err", sync_err_cnt, 16'd0);
      tick();
      tick();
      reset = 1'b0;
      rdy_mode = 0;
      repeat (2) tick();
      got_q.delete();
      send_frame(6000, NC, NC - 1);
      drain();
      check("t6_silent", got_q.size(), 0);
      check("t6_err_after", sync_err_cnt, 16'd0);
      set_mask(32'h1, 0, 0, 0);
      send_frame(7000, NC, NC - 1);
      drain();
      check("t6_reprog_count", got_q.size(), 1);
      check("t6_reprog_b0", got_q[0], {1'b1, 32'd7000});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
